// File: rtl/game_sprite_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : game_sprite_pkg                                                  |
// | Purpose : Shared types and constants for the animated sprite block.        |
// |           edge_mode_t selects how a sprite axis reacts at a screen edge.   |
// | Ports   : none (package)                                                   |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
`ifndef GAME_RGB_WIDTH
`define GAME_RGB_WIDTH 3
`endif

package game_sprite_pkg;

    localparam int PIXEL_CODE_W = 4;

    typedef enum logic [1:0] {
        EDGE_STOP   = 2'd0,
        EDGE_WRAP   = 2'd1,
        EDGE_BOUNCE = 2'd2
    } edge_mode_t;

    // Raw code 3 is not a defined mode and behaves as STOP.
    function automatic edge_mode_t decode_edge_mode(input logic [1:0] raw);
        case (raw)
            2'd1:    return EDGE_WRAP;
            2'd2:    return EDGE_BOUNCE;
            default: return EDGE_STOP;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/game_sprite_anim_display.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : game_sprite_anim_display                                         |
// | Purpose : Hit test of the beam pixel against the sprite box, bitmap lookup |
// |           in the current frame, registered colour output (1 clk latency).  |
// | Ports   : clk, rst_n (async active-low), pixel_x_i/pixel_y_i beam pixel,  |
// |           sprite_x_i/sprite_y_i top-left corner, frame_idx_i frame,        |
// |           rgb_en_o opaque flag, rgb_o colour (0 when not opaque).          |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module game_sprite_anim_display
    import game_sprite_pkg::*;
#(
    parameter int SPRITE_WIDTH  = 8,
    parameter int SPRITE_HEIGHT = 8,
    parameter int N_FRAMES      = 4,
    parameter int W_X           = 10,
    parameter int W_Y           = 9,
    parameter int FRAME_W       = 2,
    parameter int RGB_W         = 3,
    parameter logic [N_FRAMES*SPRITE_HEIGHT*SPRITE_WIDTH*PIXEL_CODE_W-1:0] BITMAP = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [W_X-1:0]     pixel_x_i,
    input  logic [W_Y-1:0]     pixel_y_i,
    input  logic [W_X-1:0]     sprite_x_i,
    input  logic [W_Y-1:0]     sprite_y_i,
    input  logic [FRAME_W-1:0] frame_idx_i,
    output logic               rgb_en_o,
    output logic [RGB_W-1:0]   rgb_o
);

    localparam int COL_W = (SPRITE_WIDTH  > 1) ? $clog2(SPRITE_WIDTH)  : 1;
    localparam int ROW_W = (SPRITE_HEIGHT > 1) ? $clog2(SPRITE_HEIGHT) : 1;
    localparam int N_PIX = N_FRAMES * SPRITE_HEIGHT * SPRITE_WIDTH;
    localparam int NIB_W = (N_PIX > 1) ? $clog2(N_PIX) : 1;

    logic                    w_in_x;
    logic                    w_in_y;
    logic [COL_W-1:0]        w_col;
    logic [ROW_W-1:0]        w_row;
    logic [NIB_W-1:0]        w_nib;
    logic [PIXEL_CODE_W-1:0] w_code;
    logic                    w_opaque;
    logic                    rgb_en_q;
    logic [RGB_W-1:0]        rgb_q;

    always_comb begin
        // One extra bit so x+W-1 near the top of the coordinate range cannot wrap.
        w_in_x = ({1'b0, pixel_x_i} >= {1'b0, sprite_x_i}) &&
                 ({1'b0, pixel_x_i} <  ({1'b0, sprite_x_i} + (W_X+1)'(SPRITE_WIDTH)));
        w_in_y = ({1'b0, pixel_y_i} >= {1'b0, sprite_y_i}) &&
                 ({1'b0, pixel_y_i} <  ({1'b0, sprite_y_i} + (W_Y+1)'(SPRITE_HEIGHT)));
        w_col  = COL_W'(pixel_x_i - sprite_x_i);
        w_row  = ROW_W'(pixel_y_i - sprite_y_i);
        w_nib  = NIB_W'((int'(frame_idx_i) * SPRITE_HEIGHT + int'(w_row)) * SPRITE_WIDTH
                        + int'(w_col));
        // Nibble index times four selects the 4-bit code.
        w_code   = BITMAP[{w_nib, 2'b00} +: PIXEL_CODE_W];
        w_opaque = w_in_x && w_in_y && (w_code != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_en_q <= 1'b0;
            rgb_q    <= '0;
        end else begin
            rgb_en_q <= w_opaque;
            rgb_q    <= w_opaque ? w_code[RGB_W-1:0] : '0;
        end
    end

    assign rgb_en_o = rgb_en_q;
    assign rgb_o    = rgb_q;

endmodule

`default_nettype wire

// File: rtl/game_sprite_anim_top.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : game_sprite_anim_top                                             |
// | Purpose : One moving, animated sprite: position/speed registers with       |
// |           per-axis STOP/WRAP/BOUNCE edge handling, frame animation and a   |
// |           registered pixel output for the screen mixer.                    |
// | Ports   : clk, rst_n (async active-low); pixel_x_i/pixel_y_i beam pixel;   |
// |           sprite_write_* position/speed/mode loads; sprite_enable_update_i,|
// |           anim_enable_i, frame_write_i/frame_write_idx_i animation control;|
// |           sprite_x_o/y_o, sprite_dx_o/dy_o, frame_idx_o state; rgb_en_o,   |
// |           rgb_o pixel output; hit_wall_o edge-event pulse.                 |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module game_sprite_anim_top
    import game_sprite_pkg::*;
#(
    parameter int SPRITE_WIDTH  = 8,
    parameter int SPRITE_HEIGHT = 8,
    parameter int N_FRAMES      = 4,
    parameter int FRAME_DIV     = 8,
    parameter int DX_WIDTH      = 3,
    parameter int DY_WIDTH      = 3,
    parameter int SCREEN_WIDTH  = 640,
    parameter int SCREEN_HEIGHT = 480,
    parameter int STROBE_W      = 20,
    parameter logic [N_FRAMES*SPRITE_HEIGHT*SPRITE_WIDTH*PIXEL_CODE_W-1:0] BITMAP = '0,
    localparam int W_X     = $clog2(SCREEN_WIDTH),
    localparam int W_Y     = $clog2(SCREEN_HEIGHT),
    localparam int FRAME_W = (N_FRAMES > 1) ? $clog2(N_FRAMES) : 1,
    localparam int RGB_W   = `GAME_RGB_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [W_X-1:0]             pixel_x_i,
    input  logic [W_Y-1:0]             pixel_y_i,
    input  logic                       sprite_write_xy_i,
    input  logic [W_X-1:0]             sprite_write_x_i,
    input  logic [W_Y-1:0]             sprite_write_y_i,
    input  logic                       sprite_write_dxy_i,
    input  logic signed [DX_WIDTH-1:0] sprite_write_dx_i,
    input  logic signed [DY_WIDTH-1:0] sprite_write_dy_i,
    input  logic [1:0]                 edge_mode_x_i,
    input  logic [1:0]                 edge_mode_y_i,
    input  logic                       sprite_enable_update_i,
    input  logic                       anim_enable_i,
    input  logic                       frame_write_i,
    input  logic [FRAME_W-1:0]         frame_write_idx_i,
    output logic [W_X-1:0]             sprite_x_o,
    output logic [W_Y-1:0]             sprite_y_o,
    output logic signed [DX_WIDTH-1:0] sprite_dx_o,
    output logic signed [DY_WIDTH-1:0] sprite_dy_o,
    output logic [FRAME_W-1:0]         frame_idx_o,
    output logic                       rgb_en_o,
    output logic [RGB_W-1:0]           rgb_o,
    output logic                       hit_wall_o
);

    // Common signed width wide enough for either axis plus a sign bit and headroom.
    localparam int AW     = ((W_X > W_Y) ? W_X : W_Y) + 2;
    localparam int FDIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic signed [AW-1:0] C_XMAX = AW'(SCREEN_WIDTH  - SPRITE_WIDTH);
    localparam logic signed [AW-1:0] C_YMAX = AW'(SCREEN_HEIGHT - SPRITE_HEIGHT);

    logic [STROBE_W-1:0]        strobe_cnt_q;
    logic [W_X-1:0]             x_q;
    logic [W_Y-1:0]             y_q;
    logic signed [DX_WIDTH-1:0] dx_q;
    logic signed [DY_WIDTH-1:0] dy_q;
    edge_mode_t                 mode_x_q;
    edge_mode_t                 mode_y_q;
    logic [FRAME_W-1:0]         frame_q;
    logic [FDIV_W-1:0]          fdiv_q;
    logic                       hit_wall_q;

    logic                       w_upd;
    logic signed [AW-1:0]       x_d;
    logic signed [AW-1:0]       y_d;
    logic                       w_hit_x;
    logic                       w_hit_y;
    logic                       w_flip_x;
    logic                       w_flip_y;
    logic signed [DX_WIDTH-1:0] dx_d;
    logic signed [DY_WIDTH-1:0] dy_d;
    logic [FRAME_W-1:0]         w_frame_load;

    // Moves one axis by its speed and applies the edge rule. Landing exactly on
    // 0 or lim is not an edge event.
    function automatic void axis_step(
        input  logic signed [AW-1:0] pos,
        input  logic signed [AW-1:0] spd,
        input  logic signed [AW-1:0] lim,
        input  edge_mode_t           mode,
        output logic signed [AW-1:0] new_pos,
        output logic                 hit,
        output logic                 flip
    );
        logic signed [AW-1:0] n;
        n       = pos + spd;
        new_pos = n;
        hit     = 1'b0;
        flip    = 1'b0;
        if (n > lim) begin
            hit     = 1'b1;
            new_pos = (mode == EDGE_WRAP) ? (n - lim - AW'(1)) : lim;
            flip    = (mode == EDGE_BOUNCE);
        end else if (n[AW-1]) begin
            hit     = 1'b1;
            new_pos = (mode == EDGE_WRAP) ? (n + lim + AW'(1)) : '0;
            flip    = (mode == EDGE_BOUNCE);
        end
    endfunction

    always_comb begin
        w_upd = (strobe_cnt_q == '0) && sprite_enable_update_i;
        axis_step(AW'({1'b0, x_q}), AW'(dx_q), C_XMAX, mode_x_q, x_d, w_hit_x, w_flip_x);
        axis_step(AW'({1'b0, y_q}), AW'(dy_q), C_YMAX, mode_y_q, y_d, w_hit_y, w_flip_y);
        // Negating the most-negative speed would overflow; saturate to max positive.
        dx_d = (dx_q == {1'b1, {(DX_WIDTH-1){1'b0}}}) ? {1'b0, {(DX_WIDTH-1){1'b1}}} : -dx_q;
        dy_d = (dy_q == {1'b1, {(DY_WIDTH-1){1'b0}}}) ? {1'b0, {(DY_WIDTH-1){1'b1}}} : -dy_q;
        w_frame_load = ({1'b0, frame_write_idx_i} >= (FRAME_W+1)'(N_FRAMES)) ? '0
                                                                             : frame_write_idx_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            strobe_cnt_q <= '0;
            x_q          <= '0;
            y_q          <= '0;
            dx_q         <= '0;
            dy_q         <= '0;
            mode_x_q     <= EDGE_STOP;
            mode_y_q     <= EDGE_STOP;
            frame_q      <= '0;
            fdiv_q       <= '0;
            hit_wall_q   <= 1'b0;
        end else begin
            strobe_cnt_q <= strobe_cnt_q + STROBE_W'(1);
            hit_wall_q   <= w_upd && (w_hit_x || w_hit_y);

            // Host writes take precedence over the motion result of the same cycle.
            if (sprite_write_xy_i) begin
                x_q <= sprite_write_x_i;
                y_q <= sprite_write_y_i;
            end else if (w_upd) begin
                x_q <= W_X'(x_d);
                y_q <= W_Y'(y_d);
            end

            if (sprite_write_dxy_i) begin
                dx_q     <= sprite_write_dx_i;
                dy_q     <= sprite_write_dy_i;
                mode_x_q <= decode_edge_mode(edge_mode_x_i);
                mode_y_q <= decode_edge_mode(edge_mode_y_i);
            end else if (w_upd) begin
                if (w_flip_x) dx_q <= dx_d;
                if (w_flip_y) dy_q <= dy_d;
            end

            if (frame_write_i) begin
                frame_q <= w_frame_load;
                fdiv_q  <= '0;
            end else if (w_upd && anim_enable_i) begin
                if (fdiv_q == FDIV_W'(FRAME_DIV - 1)) begin
                    fdiv_q  <= '0;
                    frame_q <= (frame_q == FRAME_W'(N_FRAMES - 1)) ? '0 : frame_q + FRAME_W'(1);
                end else begin
                    fdiv_q <= fdiv_q + FDIV_W'(1);
                end
            end
        end
    end

    game_sprite_anim_display #(
        .SPRITE_WIDTH  (SPRITE_WIDTH),
        .SPRITE_HEIGHT (SPRITE_HEIGHT),
        .N_FRAMES      (N_FRAMES),
        .W_X           (W_X),
        .W_Y           (W_Y),
        .FRAME_W       (FRAME_W),
        .RGB_W         (RGB_W),
        .BITMAP        (BITMAP)
    ) u_display (
        .clk         (clk),
        .rst_n       (rst_n),
        .pixel_x_i   (pixel_x_i),
        .pixel_y_i   (pixel_y_i),
        .sprite_x_i  (x_q),
        .sprite_y_i  (y_q),
        .frame_idx_i (frame_q),
        .rgb_en_o    (rgb_en_o),
        .rgb_o       (rgb_o)
    );

    assign sprite_x_o  = x_q;
    assign sprite_y_o  = y_q;
    assign sprite_dx_o = dx_q;
    assign sprite_dy_o = dy_q;
    assign frame_idx_o = frame_q;
    assign hit_wall_o  = hit_wall_q;

endmodule

`default_nettype wire

// File: tb/tb_game_sprite_anim_top.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_game_sprite_anim_top                                          |
// | Purpose : Self-checking bench for game_sprite_anim_top (640x480, 8x8,      |
// |           3 frames, FRAME_DIV 2, update every 4 clk) with a behavioural    |
// |           reference model and randomized stimulus.                         |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_game_sprite_anim_top;
    import game_sprite_pkg::*;

    localparam int SW = 640, SH = 480, W = 8, H = 8, NF = 3, FD = 2;
    localparam int XMAX = SW - W, YMAX = SH - H;
    localparam int RGBW = `GAME_RGB_WIDTH;

    function automatic logic [3:0] code_of(input int i);
        if (i == 0) return 4'hc;
        return 4'((i * 37 + i / 5) % 16);
    endfunction

    function automatic logic [NF*H*W*4-1:0] make_bitmap();
        logic [NF*H*W*4-1:0] b;
        b = '0;
        for (int i = 0; i < NF * H * W; i++) b[i*4 +: 4] = code_of(i);
        return b;
    endfunction

    localparam logic [NF*H*W*4-1:0] BMP = make_bitmap();

    logic              clk = 1'b0;
    logic              rst_n;
    logic [9:0]        pixel_x, wx, sx;
    logic [8:0]        pixel_y, wy, sy;
    logic              wr_xy, wr_dxy, en_upd, anim, fw, rgb_en, hit;
    logic signed [2:0] wdx, wdy, sdx, sdy;
    logic [1:0]        mode_x, mode_y, fidx, frame;
    logic [RGBW-1:0]   rgb;

    always #5 clk = ~clk;

    game_sprite_anim_top #(
        .SPRITE_WIDTH(W), .SPRITE_HEIGHT(H), .N_FRAMES(NF), .FRAME_DIV(FD),
        .DX_WIDTH(3), .DY_WIDTH(3), .SCREEN_WIDTH(SW), .SCREEN_HEIGHT(SH),
        .STROBE_W(2), .BITMAP(BMP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pixel_x_i(pixel_x), .pixel_y_i(pixel_y),
        .sprite_write_xy_i(wr_xy), .sprite_write_x_i(wx), .sprite_write_y_i(wy),
        .sprite_write_dxy_i(wr_dxy), .sprite_write_dx_i(wdx), .sprite_write_dy_i(wdy),
        .edge_mode_x_i(mode_x), .edge_mode_y_i(mode_y), .sprite_enable_update_i(en_upd),
        .anim_enable_i(anim), .frame_write_i(fw), .frame_write_idx_i(fidx),
        .sprite_x_o(sx), .sprite_y_o(sy), .sprite_dx_o(sdx), .sprite_dy_o(sdy),
        .frame_idx_o(frame), .rgb_en_o(rgb_en), .rgb_o(rgb), .hit_wall_o(hit)
    );

    int n_checks, n_errors;
    int m_x, m_y, m_dx, m_dy, m_mx, m_my, m_frame, m_ac, m_phase, m_rgb;
    bit m_hit, m_rgb_en, m_upd;

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_x = 0; m_y = 0; m_dx = 0; m_dy = 0; m_mx = 0; m_my = 0;
        m_frame = 0; m_ac = 0; m_phase = 0; m_rgb = 0;
        m_hit = 0; m_rgb_en = 0; m_upd = 0;
    endtask

    function automatic void m_axis(input int p, input int d, input int lim, input int mode,
                                   output int np, output int nd, output bit h);
        int n;
        n = p + d; np = n; nd = d; h = 0;
        if (n > lim || n < 0) begin
            h = 1;
            if (mode == 1) np = (n > lim) ? n - (lim + 1) : n + (lim + 1);
            else begin
                np = (n > lim) ? lim : 0;
                if (mode == 2) nd = (d == -4) ? 3 : -d;
            end
        end
    endfunction

    // Advance the model across one clock edge using the inputs currently driven.
    task automatic model_edge();
        int px, py, nx, ny, ndx, ndy, c;
        bit hx, hy, upd;
        px = int'(pixel_x); py = int'(pixel_y);
        if (px >= m_x && px < m_x + W && py >= m_y && py < m_y + H) begin
            c = int'(code_of(m_frame * H * W + (py - m_y) * W + (px - m_x)));
            m_rgb_en = (c != 0);
            m_rgb    = c % (1 << RGBW);
        end else begin
            m_rgb_en = 0; m_rgb = 0;
        end
        upd = (m_phase == 0) && en_upd;
        m_axis(m_x, m_dx, XMAX, m_mx, nx, ndx, hx);
        m_axis(m_y, m_dy, YMAX, m_my, ny, ndy, hy);
        m_hit = upd && (hx || hy);
        if (wr_xy) begin m_x = int'(wx); m_y = int'(wy); end
        else if (upd) begin m_x = nx; m_y = ny; end
        if (wr_dxy) begin
            m_dx = int'(wdx); m_dy = int'(wdy);
            m_mx = (mode_x == 1 || mode_x == 2) ? int'(mode_x) : 0;
            m_my = (mode_y == 1 || mode_y == 2) ? int'(mode_y) : 0;
        end else if (upd) begin
            m_dx = ndx; m_dy = ndy;
        end
        if (fw) begin
            m_frame = (int'(fidx) >= NF) ? 0 : int'(fidx);
            m_ac = 0;
        end else if (upd && anim) begin
            m_ac++;
            if (m_ac == FD) begin m_ac = 0; m_frame = (m_frame + 1) % NF; end
        end
        m_phase = (m_phase + 1) % 4;
        m_upd = upd;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        check_val("x", int'(sx), m_x);
        check_val("y", int'(sy), m_y);
        check_val("dx", int'(sdx), m_dx);
        check_val("dy", int'(sdy), m_dy);
        check_val("frame", int'(frame), m_frame);
        check_val("hit_wall", int'(hit), int'(m_hit));
        check_val("rgb_en", int'(rgb_en), int'(m_rgb_en));
        check_val("rgb", int'(rgb), m_rgb);
    endtask

    task automatic check_reset(input string tag);
        check_val({tag, "_x"}, int'(sx), 0);
        check_val({tag, "_y"}, int'(sy), 0);
        check_val({tag, "_dx"}, int'(sdx), 0);
        check_val({tag, "_frame"}, int'(frame), 0);
        check_val({tag, "_rgb_en"}, int'(rgb_en), 0);
        check_val({tag, "_hit"}, int'(hit), 0);
    endtask

    task automatic clear_inputs();
        pixel_x = '0; pixel_y = '0; wr_xy = 0; wx = '0; wy = '0; wr_dxy = 0;
        wdx = '0; wdy = '0; mode_x = '0; mode_y = '0; en_upd = 0; anim = 0; fw = 0; fidx = '0;
    endtask

    task automatic setup(input int x, input int y, input int dx, input int dy,
                         input int mx, input int my);
        en_upd = 0; wr_xy = 1; wx = 10'(x); wy = 9'(y);
        wr_dxy = 1; wdx = 3'(dx); wdy = 3'(dy); mode_x = 2'(mx); mode_y = 2'(my);
        tick();
        wr_xy = 0; wr_dxy = 0;
    endtask

    task automatic run_to_update();
        en_upd = 1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (m_upd) break;
        end
        check_val("update_seen", int'(m_upd), 1);
    endtask

    // Idle until the next clock edge is an update edge.
    task automatic align_update();
        en_upd = 0;
        for (int i = 0; i < 8; i++) begin
            if (m_phase == 0) break;
            tick();
        end
    endtask

    task automatic rand_inputs();
        int px, py;
        en_upd = ($urandom_range(0, 9) != 0);
        anim   = ($urandom_range(0, 3) != 0);
        wr_xy  = ($urandom_range(0, 19) == 0);
        case ($urandom_range(0, 2))
            0:       begin wx = 10'($urandom_range(0, 5)); wy = 9'($urandom_range(0, 5)); end
            1:       begin wx = 10'(XMAX - $urandom_range(0, 5)); wy = 9'(YMAX - $urandom_range(0, 5)); end
            default: begin wx = 10'($urandom_range(0, XMAX)); wy = 9'($urandom_range(0, YMAX)); end
        endcase
        wr_dxy = ($urandom_range(0, 15) == 0);
        wdx = 3'($urandom_range(0, 7)); wdy = 3'($urandom_range(0, 7));
        mode_x = 2'($urandom_range(0, 3)); mode_y = 2'($urandom_range(0, 3));
        fw = ($urandom_range(0, 30) == 0);
        fidx = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 3) != 0) begin
            px = m_x + int'($urandom_range(0, 10)) - 1;
            py = m_y + int'($urandom_range(0, 10)) - 1;
        end else begin
            px = int'($urandom_range(0, SW - 1));
            py = int'($urandom_range(0, SH - 1));
        end
        if (px < 0) px = 0;
        if (px > SW - 1) px = SW - 1;
        if (py < 0) py = 0;
        if (py > SH - 1) py = SH - 1;
        pixel_x = 10'(px); pixel_y = 9'(py);
    endtask

    int exp_seq[7] = '{0, 1, 1, 2, 2, 0, 0};

    initial begin
        n_checks = 0; n_errors = 0;
        clear_inputs();
        model_reset();
        rst_n = 0;
        #2;
        check_reset("por");
        @(posedge clk);
        #1;
        rst_n = 1;

        // Bounce on X, then move back inward.
        setup(630, 100, 3, 0, EDGE_BOUNCE, EDGE_STOP);
        run_to_update();
        check_val("bounce_x", int'(sx), 632);
        check_val("bounce_dx", int'(sdx), -3);
        check_val("bounce_hit", int'(hit), 1);
        tick();
        check_val("bounce_hit_width", int'(hit), 0);
        run_to_update();
        check_val("bounce_next_x", int'(sx), 629);

        // Wrap and stop from the same start.
        setup(630, 100, 3, 0, EDGE_WRAP, EDGE_STOP);
        run_to_update();
        check_val("wrap_x", int'(sx), 0);
        check_val("wrap_dx", int'(sdx), 3);
        check_val("wrap_hit", int'(hit), 1);
        setup(630, 100, 3, 0, EDGE_STOP, EDGE_STOP);
        run_to_update();
        check_val("stop_x", int'(sx), 632);
        check_val("stop_dx", int'(sdx), 3);
        check_val("stop_hit", int'(hit), 1);

        // Y bounce on the bottom edge.
        setup(100, 470, 0, 3, EDGE_STOP, EDGE_BOUNCE);
        run_to_update();
        check_val("bounce_y", int'(sy), 472);
        check_val("bounce_dy", int'(sdy), -3);

        // Display: frame 0 pixel (0,0) has code 4'hc.
        fw = 1; fidx = 2'd0;
        setup(100, 50, 0, 0, EDGE_STOP, EDGE_STOP);
        fw = 0;
        pixel_x = 10'd100; pixel_y = 9'd50;
        tick();
        check_val("disp_en", int'(rgb_en), 1);
        check_val("disp_rgb", int'(rgb), 12 % (1 << RGBW));
        pixel_x = 10'd108;
        tick();
        check_val("disp_out_en", int'(rgb_en), 0);
        check_val("disp_out_rgb", int'(rgb), 0);

        // Animation sequence over 7 updates, then frame_write on an update cycle.
        fw = 1; fidx = 2'd0; anim = 1;
        setup(200, 200, 0, 0, EDGE_STOP, EDGE_STOP);
        fw = 0;
        for (int k = 0; k < 7; k++) begin
            run_to_update();
            check_val("anim_seq", int'(frame), exp_seq[k]);
        end
        align_update();
        en_upd = 1; fw = 1; fidx = 2'd1;
        tick();
        fw = 0;
        check_val("fwrite_frame", int'(frame), 1);
        run_to_update();
        check_val("fwrite_div_cleared", int'(frame), 1);
        anim = 0;

        // Same-cycle priority: speed write beats bounce negation.
        setup(631, 100, 2, 0, EDGE_BOUNCE, EDGE_STOP);
        align_update();
        en_upd = 1; wr_dxy = 1; wdx = -3'sd1; wdy = 3'sd0; mode_x = EDGE_BOUNCE; mode_y = EDGE_STOP;
        tick();
        wr_dxy = 0;
        check_val("prio_dx", int'(sdx), -1);
        check_val("prio_dx_x", int'(sx), 632);
        // Position write beats the update result; bounce still negates speed.
        setup(631, 100, 2, 0, EDGE_BOUNCE, EDGE_STOP);
        align_update();
        en_upd = 1; wr_xy = 1; wx = 10'd10; wy = 9'd100;
        tick();
        wr_xy = 0;
        check_val("prio_x", int'(sx), 10);
        check_val("prio_x_dx", int'(sdx), -2);

        // Randomized run with an asynchronous reset in the middle.
        for (int i = 0; i < 1500; i++) begin
            rand_inputs();
            tick();
            if (i == 700) begin
                #2 rst_n = 0;
                #1 check_reset("midrun");
                model_reset();
                clear_inputs();
                #1 rst_n = 1;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
